qa_drv_sreg_responder: RTL and testbench

FPGA-to-host half of the client status-register (SREG) read path. The host's SREG read CSR write produces a one-cycle request, carrying an enable and a 32-bit register address, in the CSR manager's state. This block forwards that request to the client and captures the 64-bit reply. It then writes the reply, tagged with the address and a sequence number, into a fixed cache line of the device status memory (DSM) for software to poll. It sits beside the CSR manager in the polled driver and shares the CCI write channel with a downstream arbiter.

---
 rtl/qa_drv_sreg_responder_pkg.sv | 25 ++
 rtl/qa_drv_sreg_responder.sv | 202 ++++++++++++++++++++
 tb/tb_qa_drv_sreg_responder.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qa_drv_sreg_responder_pkg.sv
// Shared types for the SREG read responder: FSM states, the DSM response line
// layout and the data word substituted when the client never answers.
package qa_drv_sreg_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_WRITE,
    ST_WAIT_ACK
  } sreg_state_e;

  // Field order is MSB first, so valid lands on bit 511 and data on [63:0].
  typedef struct packed {
    logic         valid;
    logic [381:0] rsvd;
    logic         timeout;
    logic [31:0]  seq;
    logic [31:0]  addr;
    logic [63:0]  data;
  } t_SREG_DSM_LINE;

  localparam logic [63:0] SREG_TIMEOUT_DATA = 64'hDEAD_DEAD_DEAD_DEAD;

endpackage

// File: rtl/qa_drv_sreg_responder.sv
// Forwards host SREG read requests to the client and posts the tagged reply to a
// fixed DSM cache line. Define QA_DRV_SREG_TIMEOUT_EN to add a client-reply timeout.
module qa_drv_sreg_responder
  import qa_drv_sreg_responder_pkg::*;
#(
  parameter int DSM_LINE_OFFSET = 2,
  parameter int CL_ADDR_WIDTH   = 32,
  parameter int TIMEOUT_BITS    = 16
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     afu_en,
  input  logic                     afu_dsm_base_valid,
  input  logic [63:0]              afu_dsm_base,
  input  logic                     sreg_req_en,
  input  logic [31:0]              sreg_req_addr,
  output logic                     sreg_rd_req,
  output logic [31:0]              sreg_rd_addr,
  input  logic                     sreg_rd_rsp_valid,
  input  logic [63:0]              sreg_rd_rsp_data,
  output logic                     tx_wr_valid,
  output logic [CL_ADDR_WIDTH-1:0] tx_wr_addr,
  output logic [511:0]             tx_wr_data,
  input  logic                     tx_wr_almost_full,
  input  logic                     rx_wr_ack,
  output logic                     busy
);

  sreg_state_e state, state_next;

  logic        req_ok;
  logic        pend_valid;
  logic [31:0] pend_addr;
  logic [31:0] cur_addr;
  logic [63:0] rsp_data_q;
  logic        rsp_timeout_q;
  logic [31:0] seq;

  logic        launch;
  logic        take_pend;
  logic [31:0] launch_addr;
  logic        rsp_take;
  logic        timeout_hit;
  logic        wr_fire;
  logic [63:0] line_data;
  logic        line_timeout;

  t_SREG_DSM_LINE           line_next;
  logic [CL_ADDR_WIDTH-1:0] line_addr;
  logic                     unused_base_bits;

  assign req_ok    = sreg_req_en & afu_en & afu_dsm_base_valid;
  assign line_addr = afu_dsm_base[CL_ADDR_WIDTH+5:6] + CL_ADDR_WIDTH'(DSM_LINE_OFFSET);
  assign unused_base_bits = ^{afu_dsm_base[63:CL_ADDR_WIDTH+6], afu_dsm_base[5:0]};

`ifdef QA_DRV_SREG_TIMEOUT_EN
  // Timeout fires in the WAIT_RSP cycle that would bring the counter to saturation.
  localparam logic [TIMEOUT_BITS-1:0] TIMER_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};
  logic [TIMEOUT_BITS-1:0] timer;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      timer <= '0;
    end else if (state == ST_ISSUE) begin
      timer <= '0;
    end else if (state == ST_WAIT_RSP && timer != TIMER_LAST) begin
      timer <= timer + 1'b1;
    end
  end
`else
  logic [TIMEOUT_BITS-1:0] unused_timer;
  assign unused_timer = '0;
`endif

  always_comb begin
    state_next  = state;
    launch      = 1'b0;
    take_pend   = 1'b0;
    launch_addr = sreg_req_addr;
    rsp_take    = 1'b0;
    timeout_hit = 1'b0;
    wr_fire     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend_valid && afu_en) begin
          take_pend   = 1'b1;
          launch      = 1'b1;
          launch_addr = pend_addr;
          state_next  = ST_ISSUE;
        end else if (req_ok) begin
          launch     = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_WAIT_RSP;
      ST_WAIT_RSP: begin
        if (sreg_rd_rsp_valid) begin
          rsp_take = 1'b1;
        end
`ifdef QA_DRV_SREG_TIMEOUT_EN
        else if (timer == TIMER_LAST) begin
          timeout_hit = 1'b1;
        end
`endif
        // A reply can go straight out so the write appears the very next cycle.
        if (rsp_take || timeout_hit) begin
          if (!tx_wr_almost_full) begin
            wr_fire    = 1'b1;
            state_next = ST_WAIT_ACK;
          end else begin
            state_next = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (!tx_wr_almost_full) begin
          wr_fire    = 1'b1;
          state_next = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: if (rx_wr_ack) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    line_data    = rsp_data_q;
    line_timeout = rsp_timeout_q;
    if (state == ST_WAIT_RSP) begin
      line_data    = rsp_take ? sreg_rd_rsp_data : SREG_TIMEOUT_DATA;
      line_timeout = timeout_hit;
    end
    line_next         = '0;
    line_next.valid   = 1'b1;
    line_next.timeout = line_timeout;
    line_next.seq     = seq;
    line_next.addr    = cur_addr;
    line_next.data    = line_data;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE);
    end
  end

  // Single-entry pending slot: newest request wins, cleared whenever the AFU is disabled.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
    end else if (!afu_en) begin
      pend_valid <= 1'b0;
    end else if (req_ok && (state != ST_IDLE || take_pend)) begin
      pend_valid <= 1'b1;
      pend_addr  <= sreg_req_addr;
    end else if (take_pend) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cur_addr      <= '0;
      sreg_rd_req   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      sreg_rd_req <= launch;
      if (launch) begin
        cur_addr <= launch_addr;
      end
      if (rsp_take || timeout_hit) begin
        rsp_data_q    <= line_data;
        rsp_timeout_q <= timeout_hit;
      end
    end
  end

  assign sreg_rd_addr = cur_addr;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      tx_wr_valid <= 1'b0;
      tx_wr_addr  <= '0;
      tx_wr_data  <= '0;
      seq         <= '0;
    end else begin
      tx_wr_valid <= wr_fire;
      if (wr_fire) begin
        tx_wr_addr <= line_addr;
        tx_wr_data <= line_next;
        seq        <= seq + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_qa_drv_sreg_responder.sv
// Randomized directed bench for qa_drv_sreg_responder; expected DSM lines come from a
// small arithmetic model. Timeout checks are compiled when QA_DRV_SREG_TIMEOUT_EN is defined.
module tb_qa_drv_sreg_responder;

  logic         clk;
  logic         resetb;
  logic         afu_en;
  logic         afu_dsm_base_valid;
  logic [63:0]  afu_dsm_base;
  logic         sreg_req_en;
  logic [31:0]  sreg_req_addr;
  logic         sreg_rd_req;
  logic [31:0]  sreg_rd_addr;
  logic         sreg_rd_rsp_valid;
  logic [63:0]  sreg_rd_rsp_data;
  logic         tx_wr_valid;
  logic [31:0]  tx_wr_addr;
  logic [511:0] tx_wr_data;
  logic         tx_wr_almost_full;
  logic         rx_wr_ack;
  logic         busy;

  int          assert_count = 0;
  int          fail_count   = 0;
  int          wr_count     = 0;
  int          rd_count     = 0;
  logic [31:0] model_seq    = 0;

  qa_drv_sreg_responder #(
    .DSM_LINE_OFFSET(2),
    .CL_ADDR_WIDTH(32),
    .TIMEOUT_BITS(4)
  ) dut (
    .clk(clk),
    .resetb(resetb),
    .afu_en(afu_en),
    .afu_dsm_base_valid(afu_dsm_base_valid),
    .afu_dsm_base(afu_dsm_base),
    .sreg_req_en(sreg_req_en),
    .sreg_req_addr(sreg_req_addr),
    .sreg_rd_req(sreg_rd_req),
    .sreg_rd_addr(sreg_rd_addr),
    .sreg_rd_rsp_valid(sreg_rd_rsp_valid),
    .sreg_rd_rsp_data(sreg_rd_rsp_data),
    .tx_wr_valid(tx_wr_valid),
    .tx_wr_addr(tx_wr_addr),
    .tx_wr_data(tx_wr_data),
    .tx_wr_almost_full(tx_wr_almost_full),
    .rx_wr_ack(rx_wr_ack),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_wr_valid === 1'b1) wr_count++;
    if (sreg_rd_req === 1'b1) rd_count++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [511:0] model_line(input logic [63:0] data, input logic [31:0] addr,
                                              input logic [31:0] seq, input logic to);
    logic [511:0] l;
    l = '0;
    l[63:0]   = data;
    l[95:64]  = addr;
    l[127:96] = seq;
    l[128]    = to;
    l[511]    = 1'b1;
    return l;
  endfunction

  function automatic logic [31:0] model_line_addr(input logic [63:0] base);
    logic [63:0] full;
    full = (base >> 6) + 64'd2;
    return full[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr);
    sreg_req_en   = 1'b1;
    sreg_req_addr = addr;
    tick();
    sreg_req_en   = 1'b0;
    sreg_req_addr = $urandom;
  endtask

  task automatic send_reply(input logic [63:0] data);
    sreg_rd_rsp_valid = 1'b1;
    sreg_rd_rsp_data  = data;
    tick();
    sreg_rd_rsp_valid = 1'b0;
    sreg_rd_rsp_data  = {$urandom, $urandom};
  endtask

  task automatic check_write(input string tag, input logic [63:0] data, input logic [31:0] addr,
                             input logic to);
    checkOutput({tag, "_valid"}, tx_wr_valid, 1'b1);
    checkOutput({tag, "_addr"}, tx_wr_addr, model_line_addr(afu_dsm_base));
    checkOutput({tag, "_data"}, tx_wr_data, model_line(data, addr, model_seq, to));
    model_seq++;
  endtask

  task automatic ack_write();
    rx_wr_ack = 1'b1;
    tick();
    rx_wr_ack = 1'b0;
    checkOutput("wr_valid_pulse", tx_wr_valid, 1'b0);
    checkOutput("idle_after_ack", busy, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [63:0] data, input int delay,
                         input int bp_cycles);
    logic bp_ok;
    applyStimulus(addr);
    checkOutput("rd_req", sreg_rd_req, 1'b1);
    checkOutput("rd_addr", sreg_rd_addr, addr);
    repeat (delay) tick();
    tx_wr_almost_full = (bp_cycles > 0);
    send_reply(data);
    if (bp_cycles > 0) begin
      bp_ok = 1'b1;
      repeat (bp_cycles) begin
        if (tx_wr_valid !== 1'b0) bp_ok = 1'b0;
        tick();
      end
      checkOutput("bp_hold", bp_ok, 1'b1);
      tx_wr_almost_full = 1'b0;
      tick();
    end
    check_write("wr", data, addr, 1'b0);
    ack_write();
  endtask

  initial begin
    int          w0;
    int          r0;
    logic [31:0] a;
    logic [63:0] d;
    resetb             = 1'b0;
    afu_en             = 1'b1;
    afu_dsm_base_valid = 1'b1;
    afu_dsm_base       = 64'h1000;
    sreg_req_en        = 1'b0;
    sreg_req_addr      = '0;
    sreg_rd_rsp_valid  = 1'b0;
    sreg_rd_rsp_data   = '0;
    tx_wr_almost_full  = 1'b0;
    rx_wr_ack          = 1'b0;
    $display("[TB] start");
    repeat (3) tick();
    resetb = 1'b1;
    tick();
    checkOutput("rst_rd_req", sreg_rd_req, 1'b0);
    checkOutput("rst_rd_addr", sreg_rd_addr, 32'h0);
    checkOutput("rst_wr_valid", tx_wr_valid, 1'b0);
    checkOutput("rst_wr_addr", tx_wr_addr, 32'h0);
    checkOutput("rst_wr_data", tx_wr_data, 512'h0);
    checkOutput("rst_busy", busy, 1'b0);

    // Basic read and back-pressure.
    do_read(32'h10, 64'h0123456789ABCDEF, 3, 0);
    checkOutput("basic_line", 32'(model_line_addr(afu_dsm_base)), 32'h42);
    do_read($urandom, {$urandom, $urandom}, 2, 20);

    // Random traffic, including a line address that wraps.
    for (int i = 0; i < 6; i++) begin
      afu_dsm_base = {$urandom, $urandom} & ~64'h3F;
      do_read($urandom, {$urandom, $urandom}, $urandom_range(1, 5), $urandom_range(0, 3));
    end
    afu_dsm_base = {26'h0, 32'hFFFF_FFFF, 6'h0};
    do_read($urandom, {$urandom, $urandom}, 1, 0);
    afu_dsm_base = 64'h1000;

    // Overlapping requests: newest pending wins.
    w0 = wr_count;
    r0 = rd_count;
    applyStimulus(32'd1);
    applyStimulus(32'd2);
    applyStimulus(32'd3);
    d = {$urandom, $urandom};
    send_reply(d);
    check_write("ovl1", d, 32'd1, 1'b0);
    ack_write();
    tick();
    checkOutput("ovl_rd_req", sreg_rd_req, 1'b1);
    checkOutput("ovl_rd_addr", sreg_rd_addr, 32'd3);
    tick();
    d = {$urandom, $urandom};
    send_reply(d);
    check_write("ovl3", d, 32'd3, 1'b0);
    ack_write();
    repeat (5) tick();
    checkOutput("ovl_writes", 32'(wr_count - w0), 32'd2);
    checkOutput("ovl_reads", 32'(rd_count - r0), 32'd2);

    // Gating.
    afu_en = 1'b0;
    applyStimulus($urandom);
    checkOutput("gate_en_rd_req", sreg_rd_req, 1'b0);
    checkOutput("gate_en_busy", busy, 1'b0);
    afu_en = 1'b1;
    afu_dsm_base_valid = 1'b0;
    applyStimulus($urandom);
    checkOutput("gate_base_rd_req", sreg_rd_req, 1'b0);
    afu_dsm_base_valid = 1'b1;

    // afu_en drops mid-transaction: it completes, pending is dropped.
    a = $urandom;
    applyStimulus(a);
    tick();
    applyStimulus($urandom);
    afu_en = 1'b0;
    tick();
    d = {$urandom, $urandom};
    send_reply(d);
    check_write("en_drop", d, a, 1'b0);
    ack_write();
    r0 = rd_count;
    repeat (6) tick();
    checkOutput("en_drop_no_pend", 32'(rd_count - r0), 32'd0);
    afu_en = 1'b1;
    tick();

    // Reset in WAIT_RSP aborts without a write; sequence restarts at 0.
    applyStimulus(32'hCAFE_0001);
    tick();
    tick();
    w0 = wr_count;
    resetb = 1'b0;
    #1;
    checkOutput("arst_rd_addr", sreg_rd_addr, 32'h0);
    checkOutput("arst_wr_data", tx_wr_data, 512'h0);
    checkOutput("arst_wr_addr", tx_wr_addr, 32'h0);
    checkOutput("arst_busy", busy, 1'b0);
    repeat (2) tick();
    resetb = 1'b1;
    model_seq = 0;
    repeat (3) tick();
    checkOutput("arst_no_write", 32'(wr_count - w0), 32'd0);
    do_read($urandom, {$urandom, $urandom}, 2, 0);

`ifdef QA_DRV_SREG_TIMEOUT_EN
    begin
      int   n;
      logic found;
      a = $urandom;
      applyStimulus(a);
      found = 1'b0;
      n = 0;
      while (!found && n < 40) begin
        tick();
        n++;
        if (tx_wr_valid === 1'b1) found = 1'b1;
      end
      checkOutput("to_found", found, 1'b1);
      checkOutput("to_latency", 32'(n), 32'd16);
      check_write("to", 64'hDEAD_DEAD_DEAD_DEAD, a, 1'b1);
      ack_write();
      w0 = wr_count;
      send_reply({$urandom, $urandom});
      repeat (5) tick();
      checkOutput("to_late_reply", 32'(wr_count - w0), 32'd0);
      checkOutput("to_late_busy", busy, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
